// File: rtl/ascon_lite_pkg.sv
// ascon_lite shared definitions: FSM encoding, trailer constant, TF table.
// Used by both the byte-serial encryptor and decryptor.
package ascon_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_DATA  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [7:0] TRAIL_C = 8'hA5;

    function automatic logic [7:0] tf_lookup(input logic [2:0] i);
        logic [7:0] v;
        v = 8'h00;
        unique case (i)
            3'd0: v = 8'h04;
            3'd1: v = 8'h0B;
            3'd2: v = 8'h1F;
            3'd3: v = 8'h14;
            3'd4: v = 8'h1A;
            3'd5: v = 8'h15;
            3'd6: v = 8'h09;
            3'd7: v = 8'h02;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ascon_lite_out_reg.sv
// ascon_lite one-deep valid/ready output register.
// A push in the same cycle as a pop keeps valid high with the new byte.
module ascon_lite_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    // load on push, drop valid on pop, wipe on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (push) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ascon_lite_decrypt.sv
// ascon_lite byte-serial decryptor: key, ciphertext, optional trailer tag.
// Trailer tag check is compiled in with `define ASCON_DEC_TAG_CHECK_EN.
module ascon_lite_decrypt
    import ascon_lite_pkg::*;
#(
    parameter int KEY_BYTES     = 16,
    parameter int DATA_BYTES    = 8,
    parameter int TRAILER_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done,
    output logic       tag_ok,
    output logic [4:0] byte_idx
);

    localparam logic [4:0] KEY_LAST  = 5'(KEY_BYTES - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_BYTES - 1);

    state_t     state;
    logic [7:0] key_byte;
    logic       mismatch;
    logic       accept;
    logic       push;
    logic [7:0] pt;

`ifdef ASCON_DEC_TAG_CHECK_EN
    localparam logic [4:0] TRAIL_LAST = 5'(TRAILER_BYTES - 1);
    logic [7:0] last_ct;
    logic [7:0] trail_exp;
    logic       trail_bad;

    // even trailer positions carry last_ct^A5, odd ones carry last_ct
    always_comb begin
        trail_exp = byte_idx[0] ? last_ct : (last_ct ^ TRAIL_C);
        trail_bad = (in_data != trail_exp);
    end
`endif

    // input readiness follows the phase; DATA also needs room downstream
    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            ST_KEY:   in_ready = 1'b1;
            ST_DATA:  in_ready = !out_valid || out_ready;
`ifdef ASCON_DEC_TAG_CHECK_EN
            ST_TRAIL: in_ready = 1'b1;
`endif
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign push   = accept && (state == ST_DATA) && !abort;
    assign pt     = in_data ^ key_byte ^ tf_lookup(byte_idx[2:0]);
    assign busy   = (state != ST_IDLE);

    ascon_lite_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .clear     (abort),
        .push      (push),
        .push_data (pt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // message sequencer: phase, byte counter, key, tag flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_idx <= 5'd0;
            key_byte <= 8'h00;
            mismatch <= 1'b0;
            done     <= 1'b0;
            tag_ok   <= 1'b0;
`ifdef ASCON_DEC_TAG_CHECK_EN
            last_ct  <= 8'h00;
`endif
        end else if (abort) begin
            state    <= ST_IDLE;
            byte_idx <= 5'd0;
            done     <= 1'b0;
            tag_ok   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !out_valid) begin
                        state    <= ST_KEY;
                        byte_idx <= 5'd0;
                        mismatch <= 1'b0;
                        tag_ok   <= 1'b0;
                    end
                end
                ST_KEY: begin
                    if (accept) begin
                        key_byte <= in_data;
                        if (byte_idx == KEY_LAST) begin
                            state    <= ST_DATA;
                            byte_idx <= 5'd0;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
`ifdef ASCON_DEC_TAG_CHECK_EN
                        last_ct <= in_data;
`endif
                        if (byte_idx == DATA_LAST) begin
                            byte_idx <= 5'd0;
`ifdef ASCON_DEC_TAG_CHECK_EN
                            state    <= ST_TRAIL;
`else
                            state    <= ST_FIN;
                            done     <= 1'b1;
                            tag_ok   <= !mismatch;
`endif
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end
`ifdef ASCON_DEC_TAG_CHECK_EN
                ST_TRAIL: begin
                    if (accept) begin
                        if (trail_bad) begin
                            mismatch <= 1'b1;
                        end
                        if (byte_idx == TRAIL_LAST) begin
                            state    <= ST_FIN;
                            byte_idx <= 5'd0;
                            done     <= 1'b1;
                            tag_ok   <= !(mismatch || trail_bad);
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end
`endif
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_lite_decrypt.sv
// Self-checking bench for ascon_lite_decrypt.
// Random messages against a queue-based reference model.
module tb_ascon_lite_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic       tag_ok;
    logic [4:0] byte_idx;

    int errs = 0;
    int checks = 0;

    logic [7:0] tf_t [8] = '{8'h04, 8'h0B, 8'h1F, 8'h14,
                             8'h1A, 8'h15, 8'h09, 8'h02};

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    bit         rdy_rand = 1'b0;
    bit         rdy_level = 1'b1;
    bit         lat_pend = 1'b0;
    logic [7:0] lat_exp;

    ascon_lite_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .tag_ok    (tag_ok),
        .byte_idx  (byte_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_pt(input logic [7:0] ct,
                                            input logic [7:0] key,
                                            input int idx);
        return ct ^ key ^ tf_t[idx % 8];
    endfunction

    // downstream ready, updated 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
    end

    // record every byte handed downstream
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    // plaintext must be presented one cycle after its ciphertext is taken
    always @(negedge clk) begin
        if (lat_pend) begin
            lat_pend = 1'b0;
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("lat_data", 32'(out_data), 32'(lat_exp));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input bit lat,
                       input logic [7:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (lat) begin
            lat_exp = e;
            lat_pend = 1'b1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            step(1);
            n++;
        end
        step(2);
        chk("drain_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("pt%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic send_head(input logic [7:0] key_last);
        start = 1'b1;
        step(1);
        start = 1'b0;
        @(negedge clk);
        chk("busy_start", 32'(busy), 32'd1);
        chk("idx_start", 32'(byte_idx), 32'd0);
        step(1);
        for (int i = 0; i < 15; i++) put(8'($urandom), 1'b0, 8'h00);
        put(key_last, 1'b0, 8'h00);
    endtask

    task automatic run_msg(input logic [7:0] key_last,
                           input logic [63:0] cts,
                           input int bad_at, input bit hold_last,
                           input bit stall);
        logic [7:0] ct;
        logic [7:0] last;
        logic [7:0] t;
        bit         exp_tag;
        send_head(key_last);
        if (stall) begin
            rdy_rand = 1'b0;
            rdy_level = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            ct = cts[8*i +: 8];
            exp_q.push_back(model_pt(ct, key_last, i));
            if (hold_last && i == 7) rdy_rand = 1'b0;
            put(ct, 1'b1, model_pt(ct, key_last, i));
            if (stall && i == 0) begin
                @(negedge clk);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                step(3);
                chk("stall_keep_valid", 32'(out_valid), 32'd1);
                rdy_level = 1'b1;
            end
            if (hold_last && i == 7) rdy_level = 1'b0;
        end
        last = cts[63:56];
        exp_tag = 1'b1;
`ifdef ASCON_DEC_TAG_CHECK_EN
        for (int i = 0; i < 16; i++) begin
            t = (i % 2 == 0) ? (last ^ 8'hA5) : last;
            if (i == bad_at) begin
                t = t ^ 8'(1 + $urandom_range(0, 254));
                exp_tag = 1'b0;
            end
            put(t, 1'b0, 8'h00);
        end
`else
        t = last;
        if (bad_at > 99) exp_tag = 1'b0;
`endif
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("tag_ok", 32'(tag_ok), 32'(exp_tag));
        chk("fin_in_ready", 32'(in_ready), 32'd0);
        step(1);
`ifndef ASCON_DEC_TAG_CHECK_EN
        in_valid = 1'b1;
        in_data = t;
`endif
        @(negedge clk);
        chk("done_drop", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("tag_hold", 32'(tag_ok), 32'(exp_tag));
        chk("no_extra_byte", 32'(in_ready), 32'd0);
        step(1);
        in_valid = 1'b0;
        if (hold_last) begin
            @(negedge clk);
            chk("held_valid", 32'(out_valid), 32'd1);
            step(1);
            start = 1'b1;
            step(1);
            start = 1'b0;
            @(negedge clk);
            chk("start_ignored", 32'(busy), 32'd0);
            step(1);
            rdy_level = 1'b1;
        end
        drain();
    endtask

    task automatic run_abort();
        logic [7:0] k;
        logic [7:0] ct;
        k = 8'($urandom);
        rdy_rand = 1'b0;
        rdy_level = 1'b1;
        send_head(k);
        for (int i = 0; i < 3; i++) begin
            ct = 8'($urandom);
            put(ct, 1'b1, model_pt(ct, k, i));
        end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_idx", 32'(byte_idx), 32'd0);
        chk("abort_tag", 32'(tag_ok), 32'd0);
        step(1);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic run_reset();
        logic [7:0] k;
        logic [7:0] ct;
        k = 8'($urandom);
        send_head(k);
`ifdef ASCON_DEC_TAG_CHECK_EN
        for (int i = 0; i < 8; i++) put(8'($urandom), 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) put(8'($urandom), 1'b0, 8'h00);
`else
        for (int i = 0; i < 5; i++) begin
            ct = 8'($urandom);
            put(ct, 1'b1, model_pt(ct, k, i));
        end
`endif
        #1;
        lat_pend = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tag", 32'(tag_ok), 32'd0);
        chk("rst_idx", 32'(byte_idx), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        #2;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_tag", 32'(tag_ok), 32'd0);
        chk("reset_idx", 32'(byte_idx), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);

        run_msg(8'h3C, {48'h0, 8'h10, 8'h00}, -1, 1'b0, 1'b0);
        run_msg(8'($urandom), {8'h55, 56'($urandom)}, -1, 1'b0, 1'b0);
        run_msg(8'($urandom), {8'h55, 56'($urandom)}, 5, 1'b0, 1'b0);
        run_msg(8'($urandom), {$urandom, $urandom}, -1, 1'b0, 1'b1);
        run_abort();
        run_msg(8'($urandom), {$urandom, $urandom}, -1, 1'b0, 1'b0);
        run_reset();
        rdy_rand = 1'b1;
        run_msg(8'($urandom), {$urandom, $urandom}, -1, 1'b1, 1'b0);
        for (int m = 0; m < 5; m++) begin
            rdy_rand = 1'b1;
            run_msg(8'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : -1,
                    1'b0, 1'b0);
        end
        rdy_rand = 1'b0;
        rdy_level = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
